// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: package common holds the data-bus request/response,
// package pipes holds pipeline payloads, access-size and exception codes and MEM FSM states.
package common;
  localparam int DBUS_W      = 64;
  localparam int DBUS_STRB_W = DBUS_W / 8;

  typedef struct packed {
    logic                   valid;
    logic [63:0]            addr;
    logic [1:0]             size;    // log2 of access bytes
    logic [DBUS_STRB_W-1:0] strobe;
    logic [DBUS_W-1:0]      data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DBUS_W-1:0] data;
  } dbus_resp_t;
endpackage

package pipes;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [1:0] {EXC_NONE, EXC_LOAD_MISALIGN, EXC_STORE_MISALIGN} exc_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    msize_t msize;
    logic   mem_unsigned;
  } control_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] srcb;
    logic [63:0]     pc;
    control_t        ctl;
    logic [4:0]      dst;
    logic            is_bubble;
  } execute_data_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [63:0]     pc;
    control_t        ctl;
    logic [4:0]      dst;
    logic            is_bubble;
    exc_t            exc;
  } memory_data_t;

  function automatic logic [7:0] size_mask(msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(logic [2:0] off, msize_t s);
    case (s)
      MSIZE1:  return 1'b0;
      MSIZE2:  return off[0];
      MSIZE4:  return |off[1:0];
      default: return |off;
    endcase
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/response bundle between the memory stage (master) and the data memory (slave).
interface mem_access_unit_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/mem_access_unit_align.sv
// Combinational byte-lane logic: store strobe/data placement and load extraction with extension.
module mem_align
  import pipes::*;
#(
  parameter int XLEN   = 64,
  parameter int DBUS_W = 64
) (
  input  logic [2:0]          offset,
  input  msize_t              size,
  input  logic                isUnsigned,
  input  logic [XLEN-1:0]     storeData,
  input  logic [DBUS_W-1:0]   rdata,
  output logic [DBUS_W/8-1:0] strobe,
  output logic [DBUS_W-1:0]   wdata,
  output logic [XLEN-1:0]     loadData
);
  localparam int SW = DBUS_W / 8;

  logic [5:0]        shamt;
  logic [DBUS_W-1:0] shifted;
  logic              signBit;

  assign shamt   = {offset, 3'b000};
  assign strobe  = SW'(size_mask(size)) << offset;
  assign wdata   = DBUS_W'(storeData) << shamt;
  assign shifted = rdata >> shamt;

  always_comb begin
    signBit  = 1'b0;
    loadData = XLEN'(shifted);
    case (size)
      MSIZE1: begin
        signBit  = !isUnsigned && shifted[7];
        loadData = {{(XLEN-8){signBit}}, shifted[7:0]};
      end
      MSIZE2: begin
        signBit  = !isUnsigned && shifted[15];
        loadData = {{(XLEN-16){signBit}}, shifted[15:0]};
      end
      MSIZE4: begin
        signBit  = !isUnsigned && shifted[31];
        loadData = {{(XLEN-32){signBit}}, shifted[31:0]};
      end
      default: loadData = XLEN'(shifted);
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus initiator: issues loads/stores from EX/MEM and stalls with Dwait until data_ok.
// Build option MISALIGN_TRAP_EN: misaligned accesses raise an exception in IDLE instead of being issued.
//
// state | meaning
// IDLE  | pass-through; a memory op launches the request with Dwait already high
// REQ   | dreq.valid held with stable fields until data_ok
// DONE  | load result presented from rdataQ; EX/MEM advances at this edge
module mem_access_unit
  import common::*, pipes::*;
#(
  parameter int XLEN   = 64,
  parameter int DBUS_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  execute_data_t     dataE,
  mem_access_unit_if.master bus,
  output logic              Dwait,
  output memory_data_t      dataM
);
  mem_state_t            state;
  dbus_req_t             reqQ;
  logic [DBUS_W-1:0]     rdataQ;
  logic                  memOp;
  logic                  trap;
  logic                  launch;
  logic [2:0]            offset;
  logic [DBUS_W/8-1:0]   strobeNext;
  logic [DBUS_W-1:0]     wdataNext;
  logic [XLEN-1:0]       loadData;
  logic                  unusedAddrOk;

  assign memOp = !dataE.is_bubble && (dataE.ctl.memread || dataE.ctl.memwrite);

`ifdef MISALIGN_TRAP_EN
  assign trap = memOp && is_misaligned(dataE.result[2:0], dataE.ctl.msize);
`else
  assign trap = 1'b0;
`endif

  assign launch       = (state == IDLE) && memOp && !trap;
  assign unusedAddrOk = bus.dresp.addr_ok;
  // Placement uses the live address at launch; extraction uses the address held with the request.
  assign offset       = (state == IDLE) ? dataE.result[2:0] : reqQ.addr[2:0];

  mem_align #(.XLEN(XLEN), .DBUS_W(DBUS_W)) u_align (
    .offset     (offset),
    .size       (dataE.ctl.msize),
    .isUnsigned (dataE.ctl.mem_unsigned),
    .storeData  (dataE.srcb),
    .rdata      (rdataQ),
    .strobe     (strobeNext),
    .wdata      (wdataNext),
    .loadData   (loadData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      reqQ   <= '0;
      rdataQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= REQ;
            reqQ.valid  <= 1'b1;
            reqQ.addr   <= 64'(dataE.result);
            reqQ.size   <= dataE.ctl.msize;
            reqQ.strobe <= strobeNext;
            reqQ.data   <= wdataNext;
          end
        end
        REQ: begin
          if (bus.dresp.data_ok) begin
            state      <= DONE;
            reqQ.valid <= 1'b0;
            rdataQ     <= bus.dresp.data;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dreq = reqQ;

  always_comb begin
    Dwait = 1'b0;
    case (state)
      IDLE:    Dwait = launch;
      REQ:     Dwait = 1'b1;
      default: Dwait = 1'b0;
    endcase
    if (reset) Dwait = 1'b0;
  end

  always_comb begin
    dataM.result    = dataE.result;
    dataM.pc        = dataE.pc;
    dataM.ctl       = dataE.ctl;
    dataM.dst       = dataE.dst;
    dataM.is_bubble = dataE.is_bubble;
    dataM.exc       = EXC_NONE;
    if (state == DONE) dataM.result = dataE.ctl.memread ? loadData : '0;
`ifdef MISALIGN_TRAP_EN
    if (state == IDLE && trap)
      dataM.exc = dataE.ctl.memread ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
`endif
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized back-to-back traffic
// checked against a byte-level reference model.
module tb_mem_access_unit;
  import common::*;
  import pipes::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          Dwait;
  memory_data_t  dataM;
  int            checks = 0;
  int            errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.XLEN(64), .DBUS_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .dataE (dataE),
    .bus   (bus),
    .Dwait (Dwait),
    .dataM (dataM)
  );

  always #5 clk = ~clk;

  // observations gathered by run_op
  int          obsWait;
  int          obsReqCycles;
  dbus_req_t   obsReq;
  bit          obsStable;
  bit          obsTimeout;
  logic [63:0] obsResult;
  logic [63:0] obsPc;
  exc_t        obsExc;

  function automatic execute_data_t mk(logic [63:0] addr, logic [63:0] srcb, bit rd, bit wr,
                                       msize_t sz, bit uns);
    execute_data_t e = '0;
    e.result           = addr;
    e.srcb             = srcb;
    e.pc               = {$urandom, $urandom};
    e.ctl.regwrite     = rd;
    e.ctl.memread      = rd;
    e.ctl.memwrite     = wr;
    e.ctl.msize        = sz;
    e.ctl.mem_unsigned = uns;
    e.dst              = 5'($urandom);
    e.is_bubble        = 1'b0;
    return e;
  endfunction

  function automatic logic [7:0] exp_strobe(int off, int n);
    logic [7:0] s = '0;
    for (int i = 0; i < n; i++) if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] exp_load(logic [63:0] rd, int off, int n, bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v;
  endfunction

  // Present one instruction and act as the memory; call right after a rising edge.
  task automatic run_op(input execute_data_t e, input int waits, input logic [63:0] rdata);
    int reqCycles = 0;
    obsWait    = 0;
    obsStable  = 1'b1;
    obsTimeout = 1'b1;
    obsReq     = '0;
    dataE      = e;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (Dwait) obsWait++;
      if (bus.dreq.valid) begin
        reqCycles++;
        if (reqCycles == 1) obsReq = bus.dreq;
        else if (bus.dreq !== obsReq) obsStable = 1'b0;
      end
      bus.dresp.data_ok = bus.dreq.valid && (reqCycles == waits + 1);
      bus.dresp.data    = bus.dresp.data_ok ? rdata : {$urandom, $urandom};
      if (!Dwait && !bus.dreq.valid) begin
        obsResult  = dataM.result;
        obsPc      = dataM.pc;
        obsExc     = dataM.exc;
        obsTimeout = 1'b0;
        @(posedge clk);
        #1;
        break;
      end
    end
    bus.dresp.data_ok = 1'b0;
    obsReqCycles = reqCycles;
  endtask

  task automatic test_reset();
    execute_data_t e;
    e = mk(64'h8000_0000, 64'h1234, 1'b1, 1'b0, MSIZE4, 1'b0);
    reset = 1'b1;
    dataE = e;
    bus.dresp = '0;
    bus.dresp.data_ok = 1'b1;
    #1;
    checks++; if (Dwait !== 1'b0) begin errors++; $display("FAIL reset_dwait: got %b expected 0", Dwait); end
    checks++; if (bus.dreq !== '0) begin errors++; $display("FAIL reset_dreq: got %h expected 0", bus.dreq); end
    checks++; if (dataM.result !== e.result) begin errors++; $display("FAIL reset_result: got %h expected %h", dataM.result, e.result); end
    checks++; if (dataM.exc !== EXC_NONE) begin errors++; $display("FAIL reset_exc: got %0d expected 0", dataM.exc); end
    @(posedge clk); #1;
    checks++; if (Dwait !== 1'b0 || bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL reset_hold: got dwait %b valid %b expected 0 0", Dwait, bus.dreq.valid); end
    bus.dresp.data_ok = 1'b0;
    dataE.is_bubble = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    run_op(mk(64'h8000_0004, 64'h0, 1'b1, 1'b0, MSIZE4, 1'b0), 0, 64'h8765_4321_0000_0000);
    checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL lw_timeout: got %b expected 0", obsTimeout); end
    checks++; if (obsReq.strobe !== 8'hF0) begin errors++; $display("FAIL lw_strobe: got %h expected f0", obsReq.strobe); end
    checks++; if (obsReq.addr !== 64'h8000_0004) begin errors++; $display("FAIL lw_addr: got %h expected 80000004", obsReq.addr); end
    checks++; if (obsWait !== 2) begin errors++; $display("FAIL lw_dwait: got %0d expected 2", obsWait); end
    checks++; if (obsResult !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL lw_result: got %h expected ffffffff87654321", obsResult); end
  endtask

  task automatic test_store_byte();
    run_op(mk(64'h8000_0003, 64'hAB, 1'b0, 1'b1, MSIZE1, 1'b0), 4, {$urandom, $urandom});
    checks++; if (obsReq.strobe !== 8'h08) begin errors++; $display("FAIL sb_strobe: got %h expected 08", obsReq.strobe); end
    checks++; if (obsReq.data !== 64'hAB00_0000) begin errors++; $display("FAIL sb_data: got %h expected ab000000", obsReq.data); end
    checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL sb_stable: got %b expected 1", obsStable); end
    checks++; if (obsReqCycles !== 5) begin errors++; $display("FAIL sb_req_cycles: got %0d expected 5", obsReqCycles); end
    checks++; if (obsWait !== 6) begin errors++; $display("FAIL sb_dwait: got %0d expected 6", obsWait); end
    checks++; if (obsResult !== 64'h0) begin errors++; $display("FAIL sb_result: got %h expected 0", obsResult); end
  endtask

  task automatic test_half_unsigned();
    run_op(mk(64'h8000_0006, 64'h0, 1'b1, 1'b0, MSIZE2, 1'b1), 1, 64'hF00D_0000_0000_0000);
    checks++; if (obsReq.strobe !== 8'hC0) begin errors++; $display("FAIL lhu_strobe: got %h expected c0", obsReq.strobe); end
    checks++; if (obsResult !== 64'hF00D) begin errors++; $display("FAIL lhu_result: got %h expected f00d", obsResult); end
  endtask

  task automatic test_reset_mid_req();
    logic [63:0] rd;
    dataE = mk(64'h8000_0010, 64'h0, 1'b1, 1'b0, MSIZE8, 1'b0);
    bus.dresp.data_ok = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.dreq.valid !== 1'b1 || Dwait !== 1'b1) begin errors++; $display("FAIL midreq_pre: got valid %b dwait %b expected 1 1", bus.dreq.valid, Dwait); end
    reset = 1'b1;
    #1;
    checks++; if (bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL midreq_valid: got %b expected 0", bus.dreq.valid); end
    checks++; if (Dwait !== 1'b0) begin errors++; $display("FAIL midreq_dwait: got %b expected 0", Dwait); end
    dataE.is_bubble = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.dreq.valid !== 1'b0 || Dwait !== 1'b0) begin errors++; $display("FAIL midreq_after: got valid %b dwait %b expected 0 0", bus.dreq.valid, Dwait); end
    end
    @(posedge clk); #1;
    rd = {$urandom, $urandom};
    run_op(mk(64'h8000_0018, 64'h0, 1'b1, 1'b0, MSIZE8, 1'b0), 0, rd);
    checks++; if (obsWait !== 2) begin errors++; $display("FAIL midreq_restart_dwait: got %0d expected 2", obsWait); end
    checks++; if (obsResult !== rd) begin errors++; $display("FAIL midreq_restart_result: got %h expected %h", obsResult, rd); end
  endtask

  task automatic test_bubble();
    execute_data_t e;
    e = mk(64'h8000_0020, 64'h55, 1'b1, 1'b0, MSIZE4, 1'b0);
    e.is_bubble = 1'b1;
    dataE = e;
    bus.dresp.data_ok = 1'b1;
    bus.dresp.data = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.dreq.valid !== 1'b0 || Dwait !== 1'b0) begin errors++; $display("FAIL bubble_idle: got valid %b dwait %b expected 0 0", bus.dreq.valid, Dwait); end
      checks++; if (dataM.result !== e.result) begin errors++; $display("FAIL bubble_result: got %h expected %h", dataM.result, e.result); end
    end
    e = mk(64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 1'b0, MSIZE8, 1'b0);
    dataE = e;
    @(negedge clk);
    checks++; if (Dwait !== 1'b0 || dataM.result !== e.result) begin errors++; $display("FAIL alu_pass: got dwait %b result %h expected 0 %h", Dwait, dataM.result, e.result); end
    bus.dresp.data_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    run_op(mk(64'h8000_0004, 64'h0, 1'b1, 1'b0, MSIZE8, 1'b0), 0, 64'h0);
    checks++; if (obsExc !== EXC_LOAD_MISALIGN) begin errors++; $display("FAIL mis_load_exc: got %0d expected %0d", obsExc, EXC_LOAD_MISALIGN); end
    checks++; if (obsReqCycles !== 0 || obsWait !== 0) begin errors++; $display("FAIL mis_load_noreq: got req %0d dwait %0d expected 0 0", obsReqCycles, obsWait); end
    run_op(mk(64'h8000_0002, 64'h77, 1'b0, 1'b1, MSIZE4, 1'b0), 0, 64'h0);
    checks++; if (obsExc !== EXC_STORE_MISALIGN) begin errors++; $display("FAIL mis_store_exc: got %0d expected %0d", obsExc, EXC_STORE_MISALIGN); end
    checks++; if (obsReqCycles !== 0 || obsWait !== 0) begin errors++; $display("FAIL mis_store_noreq: got req %0d dwait %0d expected 0 0", obsReqCycles, obsWait); end
`else
    run_op(mk(64'h8000_0001, 64'h0, 1'b1, 1'b0, MSIZE2, 1'b0), 0, 64'h0000_0000_00BE_EF00);
    checks++; if (obsReq.strobe !== 8'h06) begin errors++; $display("FAIL mis_strobe: got %h expected 06", obsReq.strobe); end
    checks++; if (obsResult !== 64'hFFFF_FFFF_FFFF_BEEF) begin errors++; $display("FAIL mis_result: got %h expected ffffffffffffbeef", obsResult); end
    checks++; if (obsExc !== EXC_NONE) begin errors++; $display("FAIL mis_exc: got %0d expected 0", obsExc); end
`endif
  endtask

  // Random ops presented back to back: each new instruction arrives right after the previous DONE edge.
  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      int            k, n, off, waits, kind;
      bit            memOp, isLoad;
      logic [63:0]   addr, srcb, rdata, expRes;
      execute_data_t e;
      k      = $urandom_range(0, 3);
      n      = 1 << k;
      off    = $urandom_range(0, 8 / n - 1) * n;
      waits  = $urandom_range(0, 3);
      kind   = $urandom_range(0, 9);
      addr   = {$urandom, $urandom};
      addr[2:0] = 3'(off);
      srcb   = {$urandom, $urandom};
      rdata  = {$urandom, $urandom};
      isLoad = (kind >= 2 && kind <= 5);
      memOp  = (kind >= 2);
      e = mk(addr, srcb, isLoad || kind == 1, kind >= 6, msize_t'(k), 1'($urandom));
      if (kind == 1) e.is_bubble = 1'b1;
      expRes = !memOp ? addr : (isLoad ? exp_load(rdata, off, n, e.ctl.mem_unsigned) : 64'h0);
      run_op(e, waits, rdata);
      checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL rnd_timeout op %0d: got %b expected 0", i, obsTimeout); end
      checks++; if (obsWait !== (memOp ? waits + 2 : 0)) begin errors++; $display("FAIL rnd_dwait op %0d: got %0d expected %0d", i, obsWait, memOp ? waits + 2 : 0); end
      checks++; if (obsReqCycles !== (memOp ? waits + 1 : 0)) begin errors++; $display("FAIL rnd_reqcycles op %0d: got %0d expected %0d", i, obsReqCycles, memOp ? waits + 1 : 0); end
      checks++; if (obsResult !== expRes) begin errors++; $display("FAIL rnd_result op %0d: got %h expected %h", i, obsResult, expRes); end
      checks++; if (obsPc !== e.pc || obsExc !== EXC_NONE) begin errors++; $display("FAIL rnd_passthru op %0d: got pc %h exc %0d expected %h 0", i, obsPc, obsExc, e.pc); end
      if (memOp) begin
        checks++; if (obsReq.addr !== addr || obsReq.size !== 2'(k)) begin errors++; $display("FAIL rnd_addr op %0d: got %h/%0d expected %h/%0d", i, obsReq.addr, obsReq.size, addr, k); end
        checks++; if (obsReq.strobe !== exp_strobe(off, n)) begin errors++; $display("FAIL rnd_strobe op %0d: got %h expected %h", i, obsReq.strobe, exp_strobe(off, n)); end
        checks++; if (obsReq.data !== (srcb << (8 * off))) begin errors++; $display("FAIL rnd_data op %0d: got %h expected %h", i, obsReq.data, srcb << (8 * off)); end
        checks++; if (obsStable !== 1'b1) begin errors++; $display("FAIL rnd_stable op %0d: got %b expected 1", i, obsStable); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_half_unsigned();
    test_reset_mid_req();
    test_bubble();
    test_misalign();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-bus initiator. It consumes the `execute_data_t` held in the EX/MEM pipeline register and issues the data-memory request for loads and stores. It holds the pipeline with `Dwait` until the bus returns `data_ok`, then presents the aligned and extended load result as `memory_data_t` to the MEM/WB register. It is the producer of `Dwait`, which the EX/MEM register consumes.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `DBUS_W`, 64: bus data width; byte strobe width is `DBUS_W/8`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `dataE` in `execute_data_t`: EX/MEM register output.
  - `result` is the effective address.
  - `ctl.memread`, `ctl.memwrite`, `ctl.msize`, `ctl.mem_unsigned` select the access.
  - `srcb` is the store data.
- `dreq` out `dbus_req_t`: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp` in `dbus_resp_t`: `addr_ok`, `data_ok`, `data`.
- `Dwait` out 1: stall request to the EX/MEM register and upstream stages.
- `dataM` out `memory_data_t`: result to MEM/WB; fields `result`, `pc`, `ctl`, `dst`, `is_bubble`, `exc`.

## Operation
- Memory op: `mem_op = !dataE.is_bubble && (ctl.memread || ctl.memwrite)`.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If `mem_op`, go to REQ next cycle.
  - `Dwait` is asserted combinationally in the same cycle.
  - `dreq.valid` is 0.
  - Non-memory instructions pass through: `dataM.result = dataE.result`, `Dwait` = 0.
- REQ:
  - `dreq.valid` = 1.
  - `addr`, `size`, `strobe` and `data` are registered on IDLE→REQ and held stable until `data_ok`.
  - `addr_ok` is informational only.
  - On `data_ok`: capture `dresp.data` into `rdata_q`, go to DONE.
- DONE:
  - `Dwait` = 0, `dreq.valid` = 0.
  - `dataM.result` is the extended value of `rdata_q` for loads, or 0 for stores.
  - The next state is unconditionally IDLE, because the EX/MEM register advances at this edge.
- Strobe and store data:
  - `strobe = size_mask << addr[2:0]`, where `size_mask` is 0x01, 0x03, 0x0F or 0xFF for byte, half, word, double.
  - `data = srcb << (8*addr[2:0])`.
- Load extraction:
  - Shift `rdata_q` right by `8*addr[2:0]` (held address).
  - Sign-extend from bit 7, 15 or 31 unless `mem_unsigned`; double needs no extension.
- `dataM.pc`, `ctl`, `dst` and `is_bubble` are copied from `dataE`, which is stable while `Dwait` is high.

## Timing
- Reset (asynchronous): state = IDLE, `dreq.valid` = 0, `dreq` fields 0, `rdata_q` = 0.
- Outputs during reset: `Dwait` = 0; `dataM` follows the IDLE path.
- Minimum memory-op latency is 3 cycles (IDLE, REQ, DONE) when `data_ok` arrives in the first REQ cycle.
- Each extra bus-wait cycle adds one cycle.
- `data_ok` outside REQ is ignored.
- Reset asserted mid-REQ drops `valid` immediately. This is the only permitted protocol abandonment.
- Back-to-back memory ops go DONE→IDLE→REQ, giving one IDLE cycle per op with `Dwait` already asserted.
- `Dwait` must not depend on `dresp.data`. It depends only on state, `mem_op`, and `data_ok`; in REQ, `Dwait` stays 1 even in the `data_ok` cycle.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - In IDLE, a `mem_op` whose `addr` is not size-aligned sets `dataM.exc` to `EXC_LOAD_MISALIGN` or `EXC_STORE_MISALIGN`.
  - No request is issued, `Dwait` = 0, and the FSM stays in IDLE.
- Undefined: the alignment check is absent, `exc` is tied to `EXC_NONE`, and misaligned accesses are issued as-is. A cross-doubleword case produces an undefined result.

## Structure
- Shared package `pipes`:
  - `memory_data_t`.
  - The `msize_t` enum: `MSIZE1`, `MSIZE2`, `MSIZE4`, `MSIZE8`.
  - The `exc_t` codes.
  - The `mem_state_t` enum.
- `dbus_req_t` and `dbus_resp_t` stay in `common`.
- Sub-module `mem_align`: a combinational strobe/shift generator plus load extractor and extender, so the bench can unit-test the alignment logic on its own.

## Test plan
- Load word at 0x8000_0004, `mem_unsigned` = 0; `data_ok` in the first REQ cycle with `dresp.data` = 0x8765_4321_0000_0000 → `strobe` 0xF0; `dataM.result` = 0xFFFF_FFFF_8765_4321; `Dwait` high for exactly 2 cycles.
- Store byte 0xAB at 0x8000_0003 with 4 bus-wait cycles → `strobe` 0x08, `data` = 0xAB00_0000, `valid` and fields stable for 5 REQ cycles, `Dwait` high 6 cycles.
- Unsigned half load at 0x...06 returning 0xF00D_0000_0000_0000 → `result` = 0xF00D.
- Reset asserted in the second REQ cycle → `valid` and `Dwait` go to 0 without waiting for a clock edge; after release, state is IDLE and no request is pending.
- Bubble with `ctl.memread` = 1, and a spurious `data_ok` in IDLE → no request, `Dwait` 0.
- With `MISALIGN_TRAP_EN`: load double at 0x...04 → `exc` = `EXC_LOAD_MISALIGN`, `valid` never asserted, `Dwait` 0.
